// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low matrix keypad scanner with row sync, debounce and key encode
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [31:0] number,
    output logic        pressed,
    output logic        key_strobe
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DEB_W   = $clog2(DEBOUNCE_CNT);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [DWELL_W-1:0] dwell;
    logic [DEB_W-1:0]   deb_cnt;
    logic [1:0]         row_sel;
    logic [3:0]         row_meta;
    logic [3:0]         row_s;
    logic [3:0]         code_q;
    logic               sel_high;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'd1;
            4'b00_01: k = 4'd2;
            4'b00_10: k = 4'd3;
            4'b00_11: k = 4'd10;
            4'b01_00: k = 4'd4;
            4'b01_01: k = 4'd5;
            4'b01_10: k = 4'd6;
            4'b01_11: k = 4'd11;
            4'b10_00: k = 4'd7;
            4'b10_01: k = 4'd8;
            4'b10_10: k = 4'd9;
            4'b10_11: k = 4'd12;
            4'b11_00: k = 4'd14;
            4'b11_01: k = 4'd0;
            4'b11_10: k = 4'd15;
            default:  k = 4'd13;
        endcase
        return k;
    endfunction

    // Lowest-index active row wins when several rows in one column are low.
    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        logic [1:0] r;
        if (!v[0])      r = 2'd0;
        else if (!v[1]) r = 2'd1;
        else if (!v[2]) r = 2'd2;
        else            r = 2'd3;
        return r;
    endfunction

    assign col      = ~(4'b0001 << idx);
    assign number   = {28'd0, code_q};
    assign sel_high = row_s[row_sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SCAN;
            idx        <= 2'd0;
            dwell      <= '0;
            deb_cnt    <= '0;
            row_sel    <= 2'd0;
            row_meta   <= 4'b1111;
            row_s      <= 4'b1111;
            code_q     <= 4'd0;
            pressed    <= 1'b0;
            key_strobe <= 1'b0;
        end else begin
            row_meta   <= row;
            row_s      <= row_meta;
            key_strobe <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (&row_s) begin
                            idx <= idx + 2'd1;
                        end else begin
                            row_sel <= lowest_low(row_s);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (sel_high) begin
                        idx   <= idx + 2'd1;
                        dwell <= '0;
                        state <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        code_q     <= key_code(row_sel, idx);
                        pressed    <= 1'b1;
                        key_strobe <= 1'b1;
                        state      <= PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    // Column stays parked on the held key, so other keys cannot roll over.
                    if (sel_high) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!sel_high) begin
                        state <= PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        pressed <= 1'b0;
                        idx     <= idx + 2'd1;
                        dwell   <= '0;
                        state   <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - bench for keypad_scanner with keypad matrix model and reference model
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] number;
    logic        pressed;
    logic        key_strobe;

    bit keys [4][4];
    int kc [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .number(number), .pressed(pressed), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && col[c] == 1'b0) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases scanning / verifying / holding / letting go, driven by run lengths.
    localparam int P_SCAN = 0, P_VERIFY = 1, P_HOLD = 2, P_LETGO = 3;
    bit         m_valid = 0;
    int         m_phase, m_idx, m_age, m_run, m_r, m_num;
    logic [3:0] m_seen1, m_seen2;
    bit         m_pressed, m_strobe;

    task automatic model_step();
        logic [3:0] rs;
        if (!rst_n) begin
            m_phase = P_SCAN; m_idx = 0; m_age = 0; m_run = 0; m_r = 0; m_num = 0;
            m_seen1 = 4'hF; m_seen2 = 4'hF; m_pressed = 0; m_strobe = 0; m_valid = 1;
            return;
        end
        rs = m_seen2;
        m_seen2 = m_seen1;
        m_seen1 = row;
        m_strobe = 0;
        case (m_phase)
            P_SCAN: begin
                if (m_age == SD - 1) begin
                    m_age = 0;
                    if (rs == 4'hF) m_idx = (m_idx + 1) % 4;
                    else begin
                        for (int b = 3; b >= 0; b--) if (!rs[b]) m_r = b;
                        m_run = 0;
                        m_phase = P_VERIFY;
                    end
                end else m_age++;
            end
            P_VERIFY: begin
                if (rs[m_r]) begin
                    m_idx = (m_idx + 1) % 4; m_age = 0; m_phase = P_SCAN;
                end else begin
                    m_run++;
                    if (m_run == DC) begin
                        m_num = kc[m_r][m_idx]; m_pressed = 1; m_strobe = 1; m_phase = P_HOLD;
                    end
                end
            end
            P_HOLD: if (rs[m_r]) begin m_run = 0; m_phase = P_LETGO; end
            default: begin
                if (!rs[m_r]) m_phase = P_HOLD;
                else begin
                    m_run++;
                    if (m_run == DC) begin
                        m_pressed = 0; m_idx = (m_idx + 1) % 4; m_age = 0; m_phase = P_SCAN;
                    end
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        logic [3:0] ec;
        if (m_valid) begin
            ec = 4'hF;
            ec[m_idx] = 1'b0;
            check("col", col, ec);
            check("number", number, 32'(m_num));
            check("pressed", pressed, m_pressed);
            check("key_strobe", key_strobe, m_strobe);
        end
        if (key_strobe === 1'b1) strobes++;
        model_step();
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pressed(input logic v, input int budget, input string name);
        int k = 0;
        while (pressed !== v && k < budget) begin
            tick();
            k++;
        end
        check(name, pressed, v);
    endtask

    // Key released at posedge+2; pressed must still be high 10 edges later and low at edge 11.
    task automatic release_timing(input string name);
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k == 10) check({name, "_hold"}, pressed, 1'b1);
            if (k == 11) check({name, "_fall"}, pressed, 1'b0);
        end
    endtask

    initial begin
        int s;
        logic [3:0] ec;

        step(3);
        check("rst_col", col, 4'b1110);
        check("rst_number", number, 32'd0);
        check("rst_pressed", pressed, 1'b0);
        check("rst_strobe", key_strobe, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            ec = 4'hF;
            ec[(k / 4) % 4] = 1'b0;
            check("scan_seq", col, ec);
        end

        step(1);
        s = strobes;
        keys[1][1] = 1;
        wait_pressed(1'b1, 200, "press5");
        check("number5", number, 32'd5);
        step(100);
        check("strobes5", strobes - s, 1);
        keys[1][1] = 0;
        release_timing("rel5");
        step(20);
        check("number5_kept", number, 32'd5);

        s = 0;
        while (col !== 4'b1011 && s < 40) begin tick(); s++; end
        check("wait_col2", col, 4'b1011);
        s = strobes;
        step(1);
        keys[3][2] = 1;
        step(5);
        keys[3][2] = 0;
        step(3);
        check("bounce_nostrobe", strobes - s, 0);
        keys[3][2] = 1;
        wait_pressed(1'b1, 200, "press15");
        check("number15", number, 32'd15);
        check("strobes15", strobes - s, 1);
        step(1);
        keys[3][2] = 0;
        wait_pressed(1'b0, 50, "rel15");

        step(1);
        keys[3][0] = 1;
        wait_pressed(1'b1, 200, "press14");
        check("number14", number, 32'd14);
        s = strobes;
        step(1);
        keys[3][0] = 0;
        step(4);
        keys[3][0] = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("relbounce_hold", pressed, 1'b1);
        end
        check("relbounce_nostrobe", strobes - s, 0);
        check("number14_kept", number, 32'd14);
        step(1);
        keys[3][0] = 0;
        release_timing("rel14");

        step(1);
        keys[0][3] = 1;
        keys[2][3] = 1;
        wait_pressed(1'b1, 200, "press10");
        check("number10", number, 32'd10);
        step(1);
        keys[0][3] = 0;
        keys[2][3] = 0;
        wait_pressed(1'b0, 50, "rel10");

        step(1);
        rst_n = 1'b0;
        keys[2][0] = 1;
        keys[0][2] = 1;
        step(2);
        rst_n = 1'b1;
        wait_pressed(1'b1, 200, "press7");
        check("number7", number, 32'd7);
        step(1);
        keys[2][0] = 0;
        keys[0][2] = 0;
        wait_pressed(1'b0, 50, "rel7");

        step(1);
        keys[2][2] = 1;
        wait_pressed(1'b1, 200, "press9");
        check("number9", number, 32'd9);
        step(3);
        rst_n = 1'b0;
        step(1);
        check("midrst_pressed", pressed, 1'b0);
        check("midrst_number", number, 32'd0);
        check("midrst_col", col, 4'b1110);
        check("midrst_strobe", key_strobe, 1'b0);
        rst_n = 1'b1;
        s = strobes;
        wait_pressed(1'b1, 200, "repress9");
        check("renumber9", number, 32'd9);
        step(10);
        check("restrobes9", strobes - s, 1);
        keys[2][2] = 0;
        wait_pressed(1'b0, 50, "rel9");
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
